sample_loader: RTL

SAMPLE_LOADER -- requirements
Module: sample_loader

---
 rtl/sample_loader_pkg.sv | 17 +
 rtl/sample_loader_if.sv | 26 ++
 rtl/sample_buffer.sv | 37 +++
 rtl/sample_loader.sv | 133 +++++++++++++
 4 files changed

// File: rtl/sample_loader_pkg.sv
// Shared types and sizes for the sample loader and the forward network.
// Exports data_type, default L1/L4 depths, word width and the loader FSM enum.
package sample_loader_pkg;

    localparam int DATA_W = 32;
    localparam int L1_DEF = 4;
    localparam int L4_DEF = 1;

    typedef logic signed [DATA_W-1:0] data_type;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/sample_loader_if.sv
// Stream handshake bundle feeding the sample loader.
// Ports: s_tdata/s_tvalid/s_tlast from source, s_tready back from loader.
interface sample_loader_if #(
    parameter int DW = 32
) ();

    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;

    modport master (
        output s_tdata,
        output s_tvalid,
        output s_tlast,
        input  s_tready
    );

    modport slave (
        input  s_tdata,
        input  s_tvalid,
        input  s_tlast,
        output s_tready
    );

endinterface

// File: rtl/sample_buffer.sv
// One sample worth of words: indexed single-word write or whole-array copy.
// Ports: clk, reset (sync, active-low), we/widx/wdata, cp/cdata, q (contents).
module sample_buffer #(
    parameter int N  = 5,
    parameter int DW = 32,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  logic [DW-1:0] wdata,
    input  logic          cp,
    input  logic [DW-1:0] cdata [N],
    output logic [DW-1:0] q     [N]
);

    logic [DW-1:0] mem_q [N];
    logic [DW-1:0] mem_d [N];

    always_comb begin
        mem_d = mem_q;
        if (cp) mem_d = cdata;
        if (we) mem_d[widx] = wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign q = mem_q;

endmodule

// File: rtl/sample_loader.sv
// Collects L1+L4 stream words into a fill buffer and presents them on a1/y.
// Ports: clk, reset (sync, active-low), s (stream slave), a1, y, sample_valid, sample_ack, err_len.
module sample_loader
    import sample_loader_pkg::*;
#(
    parameter int L1 = L1_DEF,
    parameter int L4 = L4_DEF,
    parameter int DW = DATA_W
) (
    input  logic                 clk,
    input  logic                 reset,
    sample_loader_if.slave       s,
    output logic signed [DW-1:0] a1 [L1],
    output logic signed [DW-1:0] y  [L4],
    output logic                 sample_valid,
    input  logic                 sample_ack,
    output logic                 err_len
);

    localparam int N  = L1 + L4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          sv_q, sv_d;
    logic          err_q, err_d;
    logic          cp_q, cp_d;

    logic          acc;
    logic          fill_we;
    logic          hold_cp;
    logic          hold_full;
    logic [DW-1:0] fill_v [N];
    logic [DW-1:0] hold_v [N];
    logic [DW-1:0] zero_v [N];

    assign zero_v = '{default: '0};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FILL;
            idx_q   <= '0;
            sv_q    <= 1'b0;
            err_q   <= 1'b0;
            cp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sv_q    <= sv_d;
            err_q   <= err_d;
            cp_q    <= cp_d;
        end
    end

    // cp_q marks a completed fill whose copy into hold happens this cycle.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sv_d      = sv_q;
        err_d     = err_q;
        cp_d      = 1'b0;
        hold_full = sv_q | cp_q;
        if (sample_ack && sv_q) sv_d = 1'b0;
        unique case (state_q)
            FILL: begin
                if (acc) begin
                    if (idx_q == LAST) begin
                        idx_d = '0;
                        if (s.s_tlast) begin
                            if (!hold_full || (sample_ack && sv_q)) cp_d = 1'b1;
                            else state_d = WAIT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = DRAIN;
                        end
                    end else if (s.s_tlast) begin
                        err_d = 1'b1;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            WAIT: begin
                if (sample_ack) state_d = FILL;
            end
            DRAIN: begin
                if (acc && s.s_tlast) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
        if (hold_cp) sv_d = 1'b1;
    end

    always_comb begin
        s.s_tready = reset && (state_q != WAIT);
        acc        = s.s_tvalid && s.s_tready;
        fill_we    = acc && (state_q == FILL);
        hold_cp    = cp_q || ((state_q == WAIT) && sample_ack);
    end

    sample_buffer #(.N(N), .DW(DW), .IW(IW)) u_fill (
        .clk   (clk),
        .reset (reset),
        .we    (fill_we),
        .widx  (idx_q),
        .wdata (s.s_tdata),
        .cp    (1'b0),
        .cdata (zero_v),
        .q     (fill_v)
    );

    sample_buffer #(.N(N), .DW(DW), .IW(IW)) u_hold (
        .clk   (clk),
        .reset (reset),
        .we    (1'b0),
        .widx  ('0),
        .wdata ('0),
        .cp    (hold_cp),
        .cdata (fill_v),
        .q     (hold_v)
    );

    always_comb begin
        for (int i = 0; i < L1; i++) a1[i] = hold_v[i];
        for (int j = 0; j < L4; j++) y[j] = hold_v[L1 + j];
    end

    assign sample_valid = sv_q;
    assign err_len      = err_q;

endmodule
